// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB slave register bank driving DSP-fabric control inputs
//
// Purpose:
//   C_NUM_REGS PowerPC-writable 32-bit control registers plus one read-only
//   status word at offset C_NUM_REGS*4. Registers flagged in C_PULSE_MASK
//   self-clear one cycle after being written (strobe/enable bits). Every
//   register write raises a one-cycle per-register write strobe.
//
// Ports:
//   OPB_Clk, OPB_Rst_n      : single clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW    : OPB request (big-endian bit numbering, bit 0 = MSB)
//   OPB_select, OPB_seqAddr : transfer request; seqAddr is ignored
//   Sl_DBus, Sl_xferAck     : registered read data / acknowledge
//   Sl_errAck/retry/toutSup : tied low
//   user_data_out           : register i at bits [32i+31:32i]
//   user_wr_stb             : one-cycle write strobe per register
//   user_status_in          : status word, read-only
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h00000000,
  parameter logic [31:0] C_HIGHADDR   = 32'h000000FF,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [15:0] C_PULSE_MASK = 16'h0000,
  parameter logic [31:0] C_RST_VAL    = 32'h00000000
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_wr_stb,
  input  logic [31:0]             user_status_in
);

  localparam logic [31:0] SPAN       = C_HIGHADDR - C_BASEADDR;
  localparam logic [29:0] STATUS_IDX = 30'(C_NUM_REGS);

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t      state;
  logic [29:0] idx_q;
  logic        rnw_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        ack_q;
  logic [31:0] rd_q;
  logic [C_NUM_REGS-1:0] stb_q;
  logic [31:0] regs [C_NUM_REGS];

  // Positional assignment converts OPB big-endian numbering to [31:0]:
  // OPB_DBus[0] lands on bit 31, OPB_BE[0] lands on be_w[3] (bits 31:24).
  logic [31:0] abus_w;
  logic [31:0] dbus_w;
  logic [3:0]  be_w;
  logic [31:0] addr_off;
  logic [29:0] idx_w;
  logic        hit;
  logic [31:0] rd_next;

  assign abus_w = OPB_ABus;
  assign dbus_w = OPB_DBus;
  assign be_w   = OPB_BE;

  // Subtracting first lets addresses below the base wrap to large offsets,
  // so one unsigned compare covers both window bounds.
  assign addr_off = abus_w - C_BASEADDR;
  assign idx_w    = addr_off[31:2];
  assign hit      = OPB_select && (addr_off <= SPAN);

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, addr_off[1:0]};

  always_comb begin
    rd_next = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_w == 30'(i)) rd_next = regs[i];
    end
    if (idx_w == STATUS_IDX) rd_next = user_status_in;
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wr,
                                              input logic [3:0]  en);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = en[b] ? wr[8*b +: 8] : cur[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state   <= IDLE;
      idx_q   <= '0;
      rnw_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
      stb_q   <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs[i] <= C_PULSE_MASK[i] ? 32'h0 : C_RST_VAL;
      end
    end else begin
      ack_q <= 1'b0;
      rd_q  <= '0;
      stb_q <= '0;
      // Pulse registers fall back to zero unless a commit below overrides.
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (C_PULSE_MASK[i]) regs[i] <= 32'h0;
      end
      case (state)
        IDLE: begin
          if (hit) begin
            idx_q   <= idx_w;
            rnw_q   <= OPB_RNW;
            be_q    <= be_w;
            wdata_q <= dbus_w;
            ack_q   <= 1'b1;
            state   <= ACK;
            if (OPB_RNW) begin
              rd_q <= rd_next;
            end else begin
              for (int i = 0; i < C_NUM_REGS; i++) begin
                if (idx_w == 30'(i)) stb_q[i] <= 1'b1;
              end
            end
          end
        end
        ACK: begin
          if (!rnw_q) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
              if (idx_q == 30'(i)) regs[i] <= merge_bytes(regs[i], wdata_q, be_q);
            end
          end
          state <= HOLD;
        end
        HOLD: begin
          // One ack per select assertion: wait for select to drop.
          if (!OPB_select) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs[g];
  end

  assign Sl_DBus     = rd_q;
  assign Sl_xferAck  = ack_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_wr_stb = stb_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - table-driven bench for opb_register_bank_ppc2simulink
module tb_opb_register_bank_ppc2simulink;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:31]   abus;
  logic [0:3]    be;
  logic [0:31]   dbus;
  logic          rnw;
  logic          sel;
  logic          seq;
  logic [0:31]   sl_dbus;
  logic          ack, err, retry, tout;
  logic [N*32-1:0] udo;
  logic [N-1:0]  stb;
  logic [31:0]   status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (32'h00000000),
    .C_HIGHADDR  (32'h000000FF),
    .C_NUM_REGS  (N),
    .C_PULSE_MASK(16'h0002),
    .C_RST_VAL   (32'h12345678)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst_n     (rst_n),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (ack),
    .Sl_errAck     (err),
    .Sl_retry      (retry),
    .Sl_toutSup    (tout),
    .user_data_out (udo),
    .user_wr_stb   (stb),
    .user_status_in(status)
  );

  typedef struct {
    logic         rnw;
    logic [31:0]  addr;
    logic [3:0]   be;     // written left to right as BE[0..3]
    logic [31:0]  data;
    logic         exp_ack;
    logic [31:0]  exp_rd;
    logic [3:0]   exp_stb;
    logic [127:0] exp_udo1; // cycle after the ack cycle
    logic [127:0] exp_udo2; // one cycle later (pulse cleared)
  } vec_t;

  localparam logic [127:0] U_RST = {32'h12345678, 32'h12345678, 32'h00000000, 32'h12345678};
  localparam logic [127:0] U_A   = {32'h12345678, 32'h12345678, 32'h00000000, 32'h12BB56DD};
  localparam logic [127:0] U_P1  = {32'h12345678, 32'h12345678, 32'h00000001, 32'h12BB56DD};
  localparam logic [127:0] U_P2  = {32'h12345678, 32'h12345678, 32'h00000002, 32'h12BB56DD};
  localparam logic [127:0] U_B   = {32'h12345678, 32'hDEADBEEF, 32'h00000000, 32'h12BB56DD};
  localparam logic [127:0] U_C   = {32'hA5345678, 32'hDEADBEEF, 32'h00000000, 32'h12BB56DD};

  vec_t vecs[17];

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic [3:0] b,
                              input logic [31:0] d, input logic ea, input logic [31:0] erd,
                              input logic [3:0] es, input logic [127:0] u1, input logic [127:0] u2);
    vec_t v;
    v.rnw = r; v.addr = a; v.be = b; v.data = d; v.exp_ack = ea; v.exp_rd = erd;
    v.exp_stb = es; v.exp_udo1 = u1; v.exp_udo2 = u2;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    abus = v.addr; be = v.be; dbus = v.data; rnw = v.rnw; sel = 1'b1;
    @(negedge clk);
    check({tag, " ack"}, 128'(ack), 128'(v.exp_ack));
    check({tag, " rdata"}, 128'(sl_dbus), 128'(v.exp_rd));
    check({tag, " stb"}, 128'(stb), 128'(v.exp_stb));
    check({tag, " tied"}, 128'({err, retry, tout}), 128'(0));
    sel = 1'b0;
    @(negedge clk);
    check({tag, " ack_once"}, 128'(ack), 128'(0));
    check({tag, " rdata_idle"}, 128'(sl_dbus), 128'(0));
    check({tag, " stb_once"}, 128'(stb), 128'(0));
    check({tag, " udo1"}, udo, v.exp_udo1);
    @(negedge clk);
    check({tag, " udo2"}, udo, v.exp_udo2);
  endtask

  initial begin
    int n_ack;

    rst_n = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    status = 32'hCAFEF00D;

    vecs[0]  = mk(0, 32'h00, 4'b0101, 32'hAABBCCDD, 1, 32'h0,        4'b0001, U_A,  U_A);
    vecs[1]  = mk(0, 32'h04, 4'b1111, 32'h00000001, 1, 32'h0,        4'b0010, U_P1, U_A);
    vecs[2]  = mk(0, 32'h04, 4'b1111, 32'h00000002, 1, 32'h0,        4'b0010, U_P2, U_A);
    vecs[3]  = mk(1, 32'h04, 4'b1111, 32'h0,        1, 32'h0,        4'b0000, U_A,  U_A);
    vecs[4]  = mk(1, 32'h00, 4'b0000, 32'h0,        1, 32'h12BB56DD, 4'b0000, U_A,  U_A);
    vecs[5]  = mk(1, 32'h10, 4'b1111, 32'h0,        1, 32'hCAFEF00D, 4'b0000, U_A,  U_A);
    vecs[6]  = mk(0, 32'h10, 4'b1111, 32'hFFFFFFFF, 1, 32'h0,        4'b0000, U_A,  U_A);
    vecs[7]  = mk(0, 32'h08, 4'b1111, 32'hDEADBEEF, 1, 32'h0,        4'b0100, U_B,  U_B);
    vecs[8]  = mk(0, 32'h0C, 4'b0000, 32'h00000000, 1, 32'h0,        4'b1000, U_B,  U_B);
    vecs[9]  = mk(0, 32'h0C, 4'b1000, 32'hA5000000, 1, 32'h0,        4'b1000, U_C,  U_C);
    vecs[10] = mk(1, 32'h0E, 4'b1111, 32'h0,        1, 32'hA5345678, 4'b0000, U_C,  U_C);
    vecs[11] = mk(1, 32'h20, 4'b1111, 32'h0,        1, 32'h0,        4'b0000, U_C,  U_C);
    vecs[12] = mk(0, 32'h20, 4'b1111, 32'hFFFFFFFF, 1, 32'h0,        4'b0000, U_C,  U_C);
    vecs[13] = mk(1, 32'h100, 4'b1111, 32'h0,       0, 32'h0,        4'b0000, U_C,  U_C);
    vecs[14] = mk(0, 32'h104, 4'b1111, 32'hFFFFFFFF, 0, 32'h0,       4'b0000, U_C,  U_C);
    vecs[15] = mk(1, 32'h14, 4'b1111, 32'h0,        1, 32'h0,        4'b0000, U_C,  U_C);
    vecs[16] = mk(1, 32'hFC, 4'b1111, 32'h0,        1, 32'h0,        4'b0000, U_C,  U_C);

    repeat (3) @(negedge clk);
    check("reset udo", udo, U_RST);
    check("reset sl", 128'({sl_dbus, ack, err, retry, tout}), 128'(0));
    check("reset stb", 128'(stb), 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Select held high: exactly one ack, next ack only after re-assert.
    @(negedge clk);
    abus = 32'h00; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    n_ack = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    check("hold one ack", 128'(n_ack), 128'(1));
    sel = 1'b0;
    @(negedge clk);
    sel = 1'b1;
    @(negedge clk);
    check("reassert ack", 128'(ack), 128'(1));
    check("reassert rdata", 128'(sl_dbus), 128'(32'h12BB56DD));
    sel = 1'b0;
    @(negedge clk);

    // Reset between the hit and its ack: transfer is lost.
    @(negedge clk);
    abus = 32'h00; rnw = 1'b0; be = 4'b1111; dbus = 32'hFFFFFFFF; sel = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst ack", 128'(ack), 128'(0));
    check("midrst stb", 128'(stb), 128'(0));
    check("midrst udo", udo, U_RST);
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst ack", 128'(ack), 128'(0));
    check("postrst udo", udo, U_RST);

    run_vec(mk(1, 32'h20,  4'b1111, 32'h0, 1, 32'h0,        4'b0000, U_RST, U_RST), "post 0x20");
    run_vec(mk(1, 32'h100, 4'b1111, 32'h0, 0, 32'h0,        4'b0000, U_RST, U_RST), "post outside");
    run_vec(mk(1, 32'h00,  4'b1111, 32'h0, 1, 32'h12345678, 4'b0000, U_RST, U_RST), "post reg0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
